dsconv_block_depthwise_window_feeder: RTL and testbench
=======================================================

Name: dsconv_block_depthwise_window_feeder

Overview:
Streaming 7x7 window generator that sits upstream of the depthwise processing element and drives its start and x0..x48 inputs. It accepts a raster-order pixel stream for one channel and keeps six rows in line buffers. For every valid (no-padding) 7x7 position it presents one packed window with a start/valid handshake. Backpressure propagates from the window side to the pixel side.

Parameters:
IMG_W, 28, feature-map width in pixels (>= K)
IMG_H, 28, feature-map height in pixels (>= K)
K, 7, kernel size; fixed at 7 (49-tap PE)
DATA_W, 18, pixel width, signed Q-format shared with PE

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
pixel_in  in  DATA_W  signed input pixel, raster order
pixel_valid  in  1  pixel_in valid
pixel_sof  in  1  qualifies pixel_in as row 0 col 0 of a new frame
pixel_ready  out  1  feeder can accept a pixel this cycle
win_flat  out  49*DATA_W  packed window; tap (r*7+c) at [(r*7+c)*DATA_W +: DATA_W]
win_valid  out  1  window valid; drives PE start
win_ready  in  1  downstream accepts window
win_last  out  1  with win_valid: last window of frame
frame_done  out  1  one-cycle pulse: last pixel of frame accepted

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): col/row counters=0, win_flat=0, win_valid=0, win_last=0, frame_done=0, state=FILL. Line-buffer contents are don't-care. A reset mid-frame discards the partial frame; the next accepted pixel is row 0 col 0.
- Accept: pixel_valid && pixel_ready. pixel_ready = !win_valid || win_ready (combinational). It reads 1 after reset.
- Line buffers: 6 rows x IMG_W x DATA_W. On accept at column col, line row k (k=0 oldest..5 newest) is read at col and the rows shift up: row k gets row k+1 at col, and row 5 gets pixel_in.
- Window shift: on accept, every window row r shifts left one column. Column 6 is loaded with the line-buffer rows 0..5 for r=0..5 and with pixel_in for r=6. Tap (r,c) = image pixel (row-6+r, col-6+c).
- Emission: if the accepted pixel has row>=6 and col>=6, win_valid=1 on the next cycle, giving 1-cycle latency. win_flat is registered and frozen while win_valid && !win_ready.
- win_valid clears on the edge where win_ready=1, unless a new window is produced on the same edge. In that case win_valid stays 1 and win_flat updates, so back-to-back windows run at one per cycle.
- win_last=1 with the window whose centre-bottom-right pixel is (IMG_H-1, IMG_W-1). There are (IMG_W-6)*(IMG_H-6) windows per frame.
- Counters: col increments on accept and wraps at IMG_W-1 to 0, incrementing row. Row wraps at IMG_H-1 to 0. frame_done pulses the cycle after the (IMG_H-1, IMG_W-1) accept.
- At a row wrap, the stale left columns are fully flushed before col reaches 6; no window is emitted for col<6.
- pixel_sof on an accepted pixel forces that pixel to be (0,0), whatever the counters hold. A pending window is still delivered; no frame_done is issued for the aborted frame.
- State machine:
  - FILL (row<6): no windows; go to RUN on the accept of (6,0).
  - RUN: windows emitted; go to STALL when win_valid && !win_ready.
  - STALL: pixel_ready=0; go back to RUN on win_ready.
  - End of frame: FILL after the accept of (IMG_H-1, IMG_W-1).
- Arithmetic: pure data movement, no rounding or sign change; values pass through bit-exact.

Test Plan:
1. IMG_W=IMG_H=8; pixel value = r*8+c; stream one frame with win_ready=1 -> 4 windows. The first appears the cycle after the 55th accept, with tap0=0, tap24=27, tap48=54. Windows 2..4 have tap0=1, 8, 9, and win_last is set on the 4th only. frame_done pulses once, after pixel 63.
2. Same frame with win_ready held low 3 cycles after the first window -> pixel_ready=0 for those 3 cycles and win_flat unchanged. No pixel is lost; subsequent windows match scenario 1.
3. pixel_valid toggled 1/0 every cycle -> the same 4 windows with identical contents. Row-wrap windows have tap0=8, i.e. no stale data.
4. rst_n=0 for one cycle after pixel 40, then a full frame -> all outputs read 0 after reset. Exactly 4 correct windows for the new frame.
5. pixel_sof asserted on pixel 30 of a frame, followed by a full 64-pixel frame -> no windows before the new frame's (6,6). The 4 correct windows follow, and there is a single frame_done.
6. Two back-to-back frames with no gap -> 8 windows, 2 win_last, 2 frame_done. Frame 2's first window has tap0 equal to frame 2 pixel (0,0).

Source files
------------

// File: rtl/dsconv_block_depthwise_window_feeder.sv
// dsconv_block_depthwise_window_feeder
//
// Streaming KxK (K=7) window generator for one feature-map channel. It keeps
// K-1 image rows in line buffers and a KxK tap shift register. For every
// valid (no-padding) window position it presents one packed window to the
// depthwise PE with a valid/ready handshake. Data moves bit-exact; nothing
// is rounded or sign-changed.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   pixel_in     signed pixel, raster order
//   pixel_valid  pixel_in is valid
//   pixel_sof    forces the accepted pixel to be row 0 col 0 of a new frame
//   pixel_ready  feeder accepts a pixel this cycle (!win_valid || win_ready)
//   win_flat     packed window, tap (r*K+c) at [(r*K+c)*DATA_W +: DATA_W]
//   win_valid    window valid (PE start)
//   win_ready    downstream accepts the window
//   win_last     with win_valid: last window of the frame
//   frame_done   one-cycle pulse after the last pixel of a frame is accepted
module dsconv_block_depthwise_window_feeder #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 7,
    parameter int DATA_W = 18
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            pixel_in,
    input  logic                         pixel_valid,
    input  logic                         pixel_sof,
    output logic                         pixel_ready,
    output logic [K*K*DATA_W-1:0]        win_flat,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic                         win_last,
    output logic                         frame_done
);

    localparam int NLB = K - 1;
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_STALL} state_t;

    state_t state, state_nxt;

    logic [CW-1:0] col, eff_col;
    logic [RW-1:0] row, eff_row;
    logic          col_last, row_last, frame_end;
    logic          accept, emit;

    logic signed [DATA_W-1:0] pix_s;
    logic signed [DATA_W-1:0] lb     [NLB][IMG_W];
    logic signed [DATA_W-1:0] lb_rd  [NLB];
    logic signed [DATA_W-1:0] tap_p0 [K][K];
    logic signed [DATA_W-1:0] tap_nxt[K][K];
    logic [K*K*DATA_W-1:0]    win_nxt_flat;

    logic [K*K*DATA_W-1:0]    win_flat_p1;
    logic                     vld_p1;
    logic                     last_p1;
    logic                     done_p1;

    assign pix_s  = signed'(pixel_in);
    assign accept = pixel_valid && pixel_ready;

    // A start-of-frame pixel overrides whatever position the counters hold.
    always_comb begin
        eff_col   = pixel_sof ? '0 : col;
        eff_row   = pixel_sof ? '0 : row;
        col_last  = (eff_col == CW'(IMG_W - 1));
        row_last  = (eff_row == RW'(IMG_H - 1));
        frame_end = col_last && row_last;
        // Outside FILL the row is >= K-1, so only the column gates emission;
        // requiring col >= K-1 also guarantees the left columns were flushed
        // after a row wrap.
        emit      = accept && (state != ST_FILL) && (eff_col >= CW'(K - 1));
    end

    always_comb begin
        for (int k = 0; k < NLB; k++) begin
            lb_rd[k] = lb[k][eff_col];
        end
    end

    // Next window: every row shifts left, newest column enters at c=K-1.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                tap_nxt[r][c] = tap_p0[r][c+1];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            tap_nxt[r][K-1] = lb_rd[r];
        end
        tap_nxt[K-1][K-1] = pix_s;
        win_nxt_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_nxt_flat[(r*K+c)*DATA_W +: DATA_W] = tap_nxt[r][c];
            end
        end
    end

    // ---- stage p0: line buffers and tap shift register (data only) ----
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NLB - 1; k++) begin
                lb[k][eff_col] <= lb_rd[k+1];
            end
            lb[NLB-1][eff_col] <= pix_s;
            tap_p0 <= tap_nxt;
        end
    end

    // FSM next-state and handshake output
    always_comb begin
        state_nxt   = state;
        pixel_ready = !vld_p1 || win_ready;
        case (state)
            ST_FILL: begin
                if (accept && !pixel_sof && (eff_row == RW'(K - 1)) && (eff_col == '0))
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (accept && (frame_end || pixel_sof))
                    state_nxt = ST_FILL;
                else if (vld_p1 && !win_ready)
                    state_nxt = ST_STALL;
            end
            ST_STALL: begin
                if (accept && (frame_end || pixel_sof))
                    state_nxt = ST_FILL;
                else if (win_ready)
                    state_nxt = ST_RUN;
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    // ---- stage p1: registered window, handshake and counters ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_FILL;
            col         <= '0;
            row         <= '0;
            win_flat_p1 <= '0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            done_p1     <= 1'b0;
        end else begin
            state   <= state_nxt;
            done_p1 <= accept && frame_end;
            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : eff_row + RW'(1);
                end else begin
                    col <= eff_col + CW'(1);
                    row <= eff_row;
                end
            end
            // A new window on the same edge as a consumed one keeps valid high.
            if (emit) begin
                vld_p1      <= 1'b1;
                last_p1     <= frame_end;
                win_flat_p1 <= win_nxt_flat;
            end else if (win_ready) begin
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end
        end
    end

    assign win_flat   = win_flat_p1;
    assign win_valid  = vld_p1;
    assign win_last   = last_p1;
    assign frame_done = done_p1;

endmodule

// File: tb/tb_dsconv_block_depthwise_window_feeder.sv
// Self-checking bench for dsconv_block_depthwise_window_feeder on an 8x8 map.
// Pixel value = base + r*8 + c; expected windows come from that formula.
module tb_dsconv_block_depthwise_window_feeder;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int K  = 7;
    localparam int DW = 18;
    localparam int TW = K*K*DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] pixel_in;
    logic          pixel_valid;
    logic          pixel_sof;
    logic          pixel_ready;
    logic [TW-1:0] win_flat;
    logic          win_valid;
    logic          win_ready;
    logic          win_last;
    logic          frame_done;

    always #5 clk = ~clk;

    dsconv_block_depthwise_window_feeder #(
        .IMG_W(W), .IMG_H(H), .K(K), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_sof(pixel_sof),
        .pixel_ready(pixel_ready),
        .win_flat(win_flat), .win_valid(win_valid), .win_ready(win_ready),
        .win_last(win_last), .frame_done(frame_done)
    );

    typedef struct {
        logic [TW-1:0] w;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;
    int nwin, nlast, ndone;

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] model_win(input int base, input int row, input int col);
        logic [TW-1:0] v;
        v = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                v[(r*K+c)*DW +: DW] = DW'(base + (row-K+1+r)*W + (col-K+1+c));
        return v;
    endfunction

    // Entered and left at posedge+1.
    task automatic send_pixel(input int base, input int row, input int col, input logic sof);
        int   n;
        logic acc;
        logic emit, eof;
        emit = (row >= K-1) && (col >= K-1);
        eof  = (row == H-1) && (col == W-1);
        pixel_in    = DW'(base + row*W + col);
        pixel_sof   = sof;
        pixel_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = pixel_ready;
            @(posedge clk);
            #1;
            n++;
        end
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        if (!acc) begin
            check("accept_timeout", TW'(0), TW'(1));
            return;
        end
        if (emit) begin
            sb.push_back('{model_win(base, row, col), eof});
            check("win_latency", TW'(win_valid), TW'(1));
        end
        check("frame_done", TW'(frame_done), TW'(eof));
    endtask

    task automatic send_frame(input int base, input bit gap, input bit sof_first, input int npix);
        for (int i = 0; i < npix; i++) begin
            send_pixel(base, i / W, i % W, logic'(sof_first && i == 0));
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic start_scn();
        nwin  = 0;
        nlast = 0;
        ndone = 0;
    endtask

    task automatic end_scn(input string tag, input int ewin, input int elast, input int edone);
        int n;
        n = 0;
        while ((sb.size() != 0 || win_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_nwin"},  TW'(nwin),  TW'(ewin));
        check({tag, "_nlast"}, TW'(nlast), TW'(elast));
        check({tag, "_ndone"}, TW'(ndone), TW'(edone));
        check({tag, "_sb_empty"}, TW'(sb.size()), TW'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        check("rst_win_flat",    win_flat,          TW'(0));
        check("rst_win_valid",   TW'(win_valid),    TW'(0));
        check("rst_win_last",    TW'(win_last),     TW'(0));
        check("rst_frame_done",  TW'(frame_done),   TW'(0));
        check("rst_pixel_ready", TW'(pixel_ready),  TW'(1));
    endtask

    // Output monitor: every valid window is compared with the scoreboard head
    // (so a stalled window must stay frozen); it is popped when consumed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) ndone++;
            if (win_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_window", TW'(1), TW'(0));
                end else begin
                    check("win_flat", win_flat, sb[0].w);
                    check("win_last", TW'(win_last), TW'(sb[0].last));
                    if (win_ready) begin
                        void'(sb.pop_front());
                        nwin++;
                        if (win_last) nlast++;
                    end
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        pixel_in    = '0;
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        win_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 1: one frame, full throughput
        start_scn();
        send_frame(0, 1'b0, 1'b0, W*H);
        end_scn("s1", 4, 1, 1);

        // 2: downstream stalls 3 cycles on the first window
        start_scn();
        fork
            send_frame(500, 1'b0, 1'b0, W*H);
            begin
                int n;
                n = 0;
                while (!win_valid && n < 1000) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("s2_stall_seen", TW'(win_valid), TW'(1));
                win_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("s2_stall_ready", TW'(pixel_ready), TW'(0));
                    @(posedge clk);
                    #1;
                end
                win_ready = 1'b1;
            end
        join
        end_scn("s2", 4, 1, 1);

        // 3: pixel_valid toggling every cycle
        start_scn();
        send_frame(-300, 1'b1, 1'b0, W*H);
        end_scn("s3", 4, 1, 1);

        // 4: reset after pixel 40, then a full frame
        start_scn();
        send_frame(0, 1'b0, 1'b0, 41);
        do_reset();
        send_frame(1000, 1'b0, 1'b0, W*H);
        end_scn("s4", 4, 1, 1);

        // 5: sof on pixel 30 restarts the frame
        start_scn();
        send_frame(0, 1'b0, 1'b0, 30);
        send_frame(300, 1'b0, 1'b1, W*H);
        end_scn("s5", 4, 1, 1);

        // 6: two back-to-back frames
        start_scn();
        send_frame(0, 1'b0, 1'b0, W*H);
        send_frame(-200, 1'b0, 1'b0, W*H);
        end_scn("s6", 8, 2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
